// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the 1-to-4 deserialising distributor:
//   lane count, lane-pointer width, FSM state type and mask constants.
package demux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [LANES-1:0] MASK_NONE = 4'b0000;
  localparam logic [LANES-1:0] MASK_FULL = 4'b1111;

endpackage

// File: rtl/demux_1to4_1bit_d.sv
// demux_1to4_1bit_d
//   Combinational 1-bit 1-to-4 demultiplexer. Input i is steered to the
//   output selected by sel; all other outputs are 0.
// Ports:
//   i      in   1      data bit to route
//   sel    in   SEL_W  output select
//   o0..o3 out  1      routed outputs (only o[sel] can be 1)
module demux_1to4_1bit_d
  import demux_pkg::*;
(
  input  logic             i,
  input  logic [SEL_W-1:0] sel,
  output logic             o0,
  output logic             o1,
  output logic             o2,
  output logic             o3
);

  always_comb begin
    o0 = i & (sel == 2'd0);
    o1 = i & (sel == 2'd1);
    o2 = i & (sel == 2'd2);
    o3 = i & (sel == 2'd3);
  end

endmodule

// File: rtl/demux_1to4_deser.sv
// demux_1to4_deser
//   Registered, handshaked 1-to-4 distributor. Serial items are written to
//   lanes o0..o3 in round-robin order; a full (or flushed partial) word is
//   then presented downstream with o_valid/o_ready.
// Ports:
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   i        in   W      serial data item
//   i_valid  in   1      source has an item on i
//   i_ready  out  1      block accepts an item this cycle
//   flush    in   1      close the current word early
//   o0..o3   out  W      registered lane data
//   o_mask   out  4      bit k set = lane k written in presented word
//   o_valid  out  1      word presented on o0..o3 / o_mask
//   o_ready  in   1      downstream consumes the word
//   sel      out  2      lane the next accepted item goes to
module demux_1to4_deser
  import demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             flush,
  output logic [W-1:0]     o0,
  output logic [W-1:0]     o1,
  output logic [W-1:0]     o2,
  output logic [W-1:0]     o3,
  output logic [LANES-1:0] o_mask,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [SEL_W-1:0] sel
);

  state_t state;
  state_t next_state;
  logic   accept;
  logic   en0;
  logic   en1;
  logic   en2;
  logic   en3;

  assign accept = i_valid & i_ready;

  // Per-lane write enables: accept routed to the lane pointed at by sel.
  demux_1to4_1bit_d u_lane_dec (
    .i   (accept),
    .sel (sel),
    .o0  (en0),
    .o1  (en1),
    .o2  (en2),
    .o3  (en3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // A word closes on the 4th accept, or on flush when it would not be empty
  // (either lanes already written or an item arriving in the flush cycle).
  always_comb begin
    next_state = state;
    case (state)
      FILL: begin
        if (accept && (sel == 2'd3)) begin
          next_state = HOLD;
        end else if (flush && (accept || (o_mask != MASK_NONE))) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (o_ready) begin
          next_state = FILL;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // Handshake outputs depend on state only, so no ready/valid feed-through.
  always_comb begin
    i_ready = (state == FILL);
    o_valid = (state == HOLD);
  end

  // Lane, mask and pointer registers. In HOLD everything is frozen until the
  // word drains, at which point the lanes are cleared so unwritten lanes of
  // the next (possibly partial) word read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0     <= '0;
      o1     <= '0;
      o2     <= '0;
      o3     <= '0;
      o_mask <= MASK_NONE;
      sel    <= '0;
    end else begin
      case (state)
        FILL: begin
          if (en0) o0 <= i;
          if (en1) o1 <= i;
          if (en2) o2 <= i;
          if (en3) o3 <= i;
          o_mask <= o_mask | {en3, en2, en1, en0};
          if (next_state == HOLD) begin
            sel <= '0;
          end else if (accept) begin
            sel <= sel + SEL_W'(1);
          end
        end
        HOLD: begin
          if (o_ready) begin
            o0     <= '0;
            o1     <= '0;
            o2     <= '0;
            o3     <= '0;
            o_mask <= MASK_NONE;
            sel    <= '0;
          end
        end
        default: begin
          sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1to4_deser.sv
// tb_demux_1to4_deser
//   Scoreboard bench for demux_1to4_deser (W=1). Stimulus pushes each
//   expected word into a queue; a monitor pops and compares on every
//   downstream transfer (o_valid & o_ready).
module tb_demux_1to4_deser;

  typedef struct packed {
    logic [3:0] lanes;   // {o3,o2,o1,o0}
    logic [3:0] mask;
  } word_t;

  logic       clk;
  logic       rst_n;
  logic       i;
  logic       i_valid;
  logic       i_ready;
  logic       flush;
  logic       o0;
  logic       o1;
  logic       o2;
  logic       o3;
  logic [3:0] o_mask;
  logic       o_valid;
  logic       o_ready;
  logic [1:0] sel;

  word_t exp_q[$];
  int    tests;
  int    fails;

  demux_1to4_deser #(.W(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .flush   (flush),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3),
    .o_mask  (o_mask),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic iv, input logic id,
                               input logic fl, input logic ordy);
    i_valid = iv;
    i       = id;
    flush   = fl;
    o_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the drive time.
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_word: got lanes %b mask %b, expected none",
                 {o3, o2, o1, o0}, o_mask);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        checkOutput("word_lanes", {4'b0, o3, o2, o1, o0}, {4'b0, e.lanes});
        checkOutput("word_mask", {4'b0, o_mask}, {4'b0, e.mask});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    i       = 1'b0;
    i_valid = 1'b0;
    flush   = 1'b0;
    o_ready = 1'b0;

    // Reset with clock running
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_lanes", {4'b0, o3, o2, o1, o0}, 8'h00);
    checkOutput("rst_mask", {4'b0, o_mask}, 8'h00);
    checkOutput("rst_o_valid", {7'b0, o_valid}, 8'h00);
    checkOutput("rst_sel", {6'b0, sel}, 8'h00);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_i_ready", {7'b0, i_ready}, 8'h01);

    // Full word 1,0,1,1 with o_ready high
    exp_q.push_back('{lanes: 4'b1101, mask: 4'b1111});
    applyStimulus(1, 1, 0, 1);
    checkOutput("full_sel_after1", {6'b0, sel}, 8'h01);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    checkOutput("full_no_valid_early", {7'b0, o_valid}, 8'h00);
    applyStimulus(1, 1, 0, 1);
    checkOutput("full_o_valid", {7'b0, o_valid}, 8'h01);
    checkOutput("full_i_ready_low", {7'b0, i_ready}, 8'h00);
    applyStimulus(1, 1, 0, 1);
    checkOutput("full_i_ready_back", {7'b0, i_ready}, 8'h01);
    checkOutput("full_sel_zero", {6'b0, sel}, 8'h00);
    checkOutput("full_drained_mask", {4'b0, o_mask}, 8'h00);

    // Backpressure: word 0,1,1,0 held for 10 cycles
    exp_q.push_back('{lanes: 4'b0110, mask: 4'b1111});
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 1, k[0], 0);
      checkOutput("bp_lanes", {4'b0, o3, o2, o1, o0}, 8'h06);
      checkOutput("bp_mask", {4'b0, o_mask}, 8'h0f);
      checkOutput("bp_i_ready", {7'b0, i_ready}, 8'h00);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_drained", {7'b0, o_valid}, 8'h00);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp_drained_once", {7'b0, o_valid}, 8'h00);

    // Partial flush after two items
    exp_q.push_back('{lanes: 4'b0011, mask: 4'b0011});
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pf_o_valid", {7'b0, o_valid}, 8'h01);
    checkOutput("pf_mask", {4'b0, o_mask}, 8'h03);
    checkOutput("pf_lanes", {4'b0, o3, o2, o1, o0}, 8'h03);
    checkOutput("pf_sel", {6'b0, sel}, 8'h00);
    applyStimulus(0, 0, 0, 1);

    // Flush together with a third accept
    exp_q.push_back('{lanes: 4'b0110, mask: 4'b0111});
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("fa_o_valid", {7'b0, o_valid}, 8'h01);
    checkOutput("fa_mask", {4'b0, o_mask}, 8'h07);
    checkOutput("fa_lanes", {4'b0, o3, o2, o1, o0}, 8'h06);
    applyStimulus(0, 0, 0, 1);

    // Flush on an empty word is ignored
    applyStimulus(0, 0, 1, 0);
    checkOutput("ef_o_valid", {7'b0, o_valid}, 8'h00);
    checkOutput("ef_i_ready", {7'b0, i_ready}, 8'h01);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ef_o_valid_later", {7'b0, o_valid}, 8'h00);

    // Reset in the middle of a word
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("mr_pre_mask", {4'b0, o_mask}, 8'h03);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_lanes", {4'b0, o3, o2, o1, o0}, 8'h00);
    checkOutput("mr_mask", {4'b0, o_mask}, 8'h00);
    checkOutput("mr_sel", {6'b0, sel}, 8'h00);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('{lanes: 4'b0100, mask: 4'b1111});
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("mr_o_valid", {7'b0, o_valid}, 8'h01);
    checkOutput("mr_lanes_after", {4'b0, o3, o2, o1, o0}, 8'h04);
    applyStimulus(0, 0, 0, 1);
    checkOutput("mr_drained", {7'b0, o_valid}, 8'h00);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
